// File: rtl/nibble_serial_adder.sv
// Nibble-serial wide adder: one 4-bit ripple-carry stage is reused once per
// clock. The carry is registered between slices, and the result is built LSB-first.

// 4-bit ripple-carry stage that the serial adder wraps.
module ripple_carry_adder (
    input  logic [3:0] in_1,
    input  logic [3:0] in_2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]       = in_1[gi] ^ in_2[gi] ^ carry[gi];
            assign carry[gi + 1] = (in_1[gi] & in_2[gi]) | (carry[gi] & (in_1[gi] ^ in_2[gi]));
        end
    endgenerate

    assign c_out = carry[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] in_1,
    input  logic [4*NIBBLES-1:0] in_2,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            c_out_q, c_out_d;

    logic            accept;
    logic            last_nibble;
    logic [3:0]      a_nib [NIBBLES];
    logic [3:0]      b_nib [NIBBLES];
    logic [3:0]      rca_sum;
    logic            rca_c_out;

    // A start is only taken when no computation is running (IDLE or the DONE cycle).
    assign accept      = start && (state_q != S_ADD);
    assign last_nibble = (idx_q == IW'(NIBBLES - 1));

    // Split the latched operands into slices so the stage input is a plain mux on idx.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign a_nib[gi] = op_a_q[4*gi +: 4];
            assign b_nib[gi] = op_b_q[4*gi +: 4];
        end
    endgenerate

    ripple_carry_adder u_rca (
        .in_1  (a_nib[idx_q]),
        .in_2  (b_nib[idx_q]),
        .c_in  (carry_q),
        .sum   (rca_sum),
        .c_out (rca_c_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE lasts one cycle unless a new start chains straight into ADD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_nibble) state_d = S_DONE;
            S_DONE:  state_d = start ? S_ADD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are a pure decode of the registered state, with no path from start.
    always_comb begin
        busy = (state_q == S_ADD);
        done = (state_q == S_DONE);
    end

    // Datapath next-state: capture operands on accept, then write one sum slice per ADD cycle.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        if (accept) begin
            op_a_d  = in_1;
            op_b_d  = in_2;
            carry_d = c_in;
            idx_d   = '0;
            sum_d   = '0;
            c_out_d = 1'b0;
        end else if (state_q == S_ADD) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IW'(i)) begin
                    sum_d[4*i +: 4] = rca_sum;
                end
            end
            carry_d = rca_c_out;
            if (last_nibble) begin
                idx_d   = '0;
                c_out_d = rca_c_out;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: a 4-nibble and a 2-nibble instance
// are checked against plain wide arithmetic, with timing taken from the handshake rules.
`timescale 1ns/1ps
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst_n;

    logic        start4, cin4, busy4, done4, cout4;
    logic [15:0] a4, b4, sum4;
    logic        start2, cin2, busy2, done2, cout2;
    logic [7:0]  a2, b2, sum2;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_1(a4), .in_2(b4), .c_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
    );

    nibble_serial_adder #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_1(a2), .in_2(b2), .c_in(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [15:0] a, input logic [15:0] b, input logic ci);
        if (sel == 0) begin
            start4 = s; a4 = a; b4 = b; cin4 = ci;
        end else begin
            start2 = s; a2 = a[7:0]; b2 = b[7:0]; cin2 = ci;
        end
    endtask

    function automatic logic f_done(input int sel);
        return (sel == 0) ? done4 : done2;
    endfunction

    function automatic logic f_busy(input int sel);
        return (sel == 0) ? busy4 : busy2;
    endfunction

    function automatic logic [15:0] f_sum(input int sel);
        return (sel == 0) ? sum4 : {8'h00, sum2};
    endfunction

    function automatic logic f_cout(input int sel);
        return (sel == 0) ? cout4 : cout2;
    endfunction

    // Reference: {c_out,sum} is the exact (W+1)-bit sum of the operands and carry.
    task automatic ref_add(input int sel, input logic [15:0] a, input logic [15:0] b, input logic ci,
                           output logic [15:0] es, output logic ec);
        logic [16:0] e;
        if (sel == 0) begin
            e  = {1'b0, a} + {1'b0, b} + 17'(ci);
            es = e[15:0];
            ec = e[16];
        end else begin
            e  = {9'b0, a[7:0]} + {9'b0, b[7:0]} + 17'(ci);
            es = {8'h00, e[7:0]};
            ec = e[8];
        end
    endtask

    // One complete operation: pulse start, scramble the operand inputs afterwards,
    // and check latency, busy duration, result and the single-cycle done pulse.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic ci, input string tag);
        int          n;
        int          lat;
        int          busy_cnt;
        logic [15:0] es;
        logic        ec;
        n = (sel == 0) ? 4 : 2;
        ref_add(sel, a, b, ci, es, ec);
        lat = -1;
        busy_cnt = 0;
        @(negedge clk);
        drive(sel, 1'b1, a, b, ci);
        @(posedge clk);
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk);
            if (k == 0) drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            if (f_done(sel)) begin
                lat = k;
                break;
            end
            if (f_busy(sel)) busy_cnt++;
        end
        check({tag, " latency"}, lat, n);
        check({tag, " busy cycles"}, busy_cnt, n);
        check({tag, " sum"}, f_sum(sel), es);
        check({tag, " c_out"}, f_cout(sel), ec);
        @(negedge clk);
        check({tag, " done pulse width"}, f_done(sel), 1'b0);
        check({tag, " sum held"}, f_sum(sel), es);
        $display("op %s: N=%0d a=%h b=%h cin=%0d -> sum=%h c_out=%0d (exp %h/%0d)",
                 tag, n, a, b, ci, f_sum(sel), f_cout(sel), es, ec);
    endtask

    initial begin
        int d;
        int done_seen;
        int lat;
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        #12;
        check("reset sum", sum4, 16'h0);
        check("reset c_out", cout4, 1'b0);
        check("reset busy", busy4, 1'b0);
        check("reset done", done4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry ripple across all slices, then no-carry and a 3-nibble chain.
        run_op(0, 16'h0001, 16'hFFFF, 1'b1, "ripple");
        run_op(0, 16'h1234, 16'h4321, 1'b0, "nocarry");
        run_op(0, 16'h0FFF, 16'h0001, 1'b0, "chain3");

        // A start pulse during ADD must be ignored.
        @(negedge clk);
        drive(0, 1'b1, 16'h0005, 16'h0003, 1'b1);
        @(posedge clk);
        done_seen = 0;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) drive(0, 1'b0, 16'h0005, 16'h0003, 1'b1);
            if (k == 1) drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
            if (k == 2) drive(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
            if (done4) begin
                done_seen++;
                if (lat < 0) begin
                    lat = k;
                    check("ignore sum", sum4, 16'h0009);
                    check("ignore c_out", cout4, 1'b0);
                end
            end
        end
        check("ignore done count", done_seen, 1);
        check("ignore latency", lat, 4);
        $display("op ignore: 0005+0003+1 with restart during ADD -> sum=%h", sum4);

        // Back-to-back with start held high.
        @(negedge clk);
        drive(0, 1'b1, 16'h8000, 16'h8000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 16'h00FF, 16'h0001, 1'b1);
        lat = 0;
        while (!done4 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("b2b first latency", lat, 4);
        check("b2b first sum", sum4, 16'h0000);
        check("b2b first c_out", cout4, 1'b1);
        d = 0;
        do begin
            @(negedge clk);
            d++;
            if (d == 1) drive(0, 1'b0, 16'h00FF, 16'h0001, 1'b1);
        end while (!done4 && d < 10);
        check("b2b spacing", d, 5);
        check("b2b second sum", sum4, 16'h0101);
        check("b2b second c_out", cout4, 1'b0);
        $display("op b2b: 8000+8000 then 00FF+0001+1, done spacing %0d", d);

        // Asynchronous reset in the second ADD cycle.
        @(negedge clk);
        drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort sum", sum4, 16'h0);
        check("abort c_out", cout4, 1'b0);
        check("abort busy", busy4, 1'b0);
        check("abort done", done4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done4) done_seen++;
        end
        check("abort no done", done_seen, 0);
        $display("op abort: reset during ADD, done pulses after release %0d", done_seen);
        run_op(0, 16'h0002, 16'h0002, 1'b0, "after_reset");

        // Two-nibble instance.
        run_op(1, 16'h00F0, 16'h001F, 1'b1, "n2_directed");

        // Randomised operations on both widths.
        for (int i = 0; i < 600; i++) begin
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), "rand4");
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        for (int i = 0; i < 500; i++) begin
            run_op(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom), "rand2");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
